// File: rtl/laser_pkg.sv
// Shared types, defaults and distance helper for the laser stimulus scorer.
package laser_pkg;

  localparam int unsigned N_POINTS_DEF    = 40;
  localparam int unsigned R_SQ_DEF        = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned SCORE_W = 6;
  localparam int unsigned D2_W    = 9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STREAM    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_SCORE     = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  // Squared Euclidean distance; squares via |dx| so the 9-bit sum is exact.
  function automatic logic [D2_W-1:0] dist_sq(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy
  );
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic [COORD_W-1:0]      ax;
    logic [COORD_W-1:0]      ay;
    logic [2*COORD_W-1:0]    sx;
    logic [2*COORD_W-1:0]    sy;
    dx = $signed({1'b0, x}) - $signed({1'b0, cx});
    dy = $signed({1'b0, y}) - $signed({1'b0, cy});
    ax = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
    ay = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
    sx = {{COORD_W{1'b0}}, ax} * {{COORD_W{1'b0}}, ax};
    sy = {{COORD_W{1'b0}}, ay} * {{COORD_W{1'b0}}, ay};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational coverage test of one point against both captured circles.
module laser_cover_chk
  import laser_pkg::*;
#(
  parameter int unsigned R_SQ = R_SQ_DEF
) (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic [3:0] i_c1x,
  input  logic [3:0] i_c1y,
  input  logic [3:0] i_c2x,
  input  logic [3:0] i_c2y,
  output logic       o_covered_c
);

  logic [D2_W-1:0] w_d2_1;
  logic [D2_W-1:0] w_d2_2;

  assign w_d2_1      = dist_sq(i_x, i_y, i_c1x, i_c1y);
  assign w_d2_2      = dist_sq(i_x, i_y, i_c2x, i_c2y);
  assign o_covered_c = (w_d2_1 <= D2_W'(R_SQ)) || (w_d2_2 <= D2_W'(R_SQ));

endmodule

// File: rtl/laser_stim_scorer.sv
// Streams a stored point burst to the LASER block, waits for its circle
// centres, then scores how many points fall inside either circle.
module laser_stim_scorer
  import laser_pkg::*;
#(
  parameter int unsigned N_POINTS    = N_POINTS_DEF,
  parameter int unsigned R_SQ        = R_SQ_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       start,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       busy,
  output logic       score_valid,
  output logic [5:0] score,
  output logic       timeout
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_idx;
  logic [SCORE_W-1:0]    r_cnt;
  logic [TMR_W-1:0]      r_tmr;
  logic [COORD_W-1:0]    r_c1x, r_c1y, r_c2x, r_c2y;
  logic [COORD_W-1:0]    r_x, r_y;
  logic                  r_busy;
  logic                  r_score_valid;
  logic [SCORE_W-1:0]    r_score;
  logic                  r_timeout;
  logic [COORD_W-1:0]    r_bx [N_POINTS];
  logic [COORD_W-1:0]    r_by [N_POINTS];

  logic                  w_wr_ok;
  logic                  w_covered;

  assign w_wr_ok = (r_state == S_IDLE) && wr_en && (32'(wr_addr) < N_POINTS);

  // Point buffer: written only while idle, deliberately not reset.
  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      r_bx[wr_addr] <= wr_x;
      r_by[wr_addr] <= wr_y;
    end
  end

  laser_cover_chk #(
    .R_SQ (R_SQ)
  ) u_cover_chk (
    .i_x         (r_bx[r_idx]),
    .i_y         (r_by[r_idx]),
    .i_c1x       (r_c1x),
    .i_c1y       (r_c1y),
    .i_c2x       (r_c2x),
    .i_c2y       (r_c2y),
    .o_covered_c (w_covered)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_c1x         <= '0;
      r_c1y         <= '0;
      r_c2x         <= '0;
      r_c2y         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_busy        <= 1'b0;
      r_score_valid <= 1'b0;
      r_score       <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_score_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
            r_idx   <= ADDR_W'(1);
            // A same-cycle write to entry 0 must reach the first streamed point.
            if (wr_en && (wr_addr == '0)) begin
              r_x <= wr_x;
              r_y <= wr_y;
            end else begin
              r_x <= r_bx[0];
              r_y <= r_by[0];
            end
          end
        end
        S_STREAM: begin
          if (32'(r_idx) == N_POINTS) begin
            r_state <= S_WAIT_DONE;
            r_idx   <= '0;
            r_tmr   <= '0;
          end else begin
            r_x   <= r_bx[r_idx];
            r_y   <= r_by[r_idx];
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (DONE) begin
            r_state <= S_SCORE;
            r_c1x   <= C1X;
            r_c1y   <= C1Y;
            r_c2x   <= C2X;
            r_c2y   <= C2Y;
            r_idx   <= '0;
            r_cnt   <= '0;
          end else if (r_tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_tmr     <= '0;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        S_SCORE: begin
          if (32'(r_idx) == N_POINTS - 1) begin
            r_state       <= S_REPORT;
            r_score       <= r_cnt + SCORE_W'(w_covered);
            r_score_valid <= 1'b1;
            r_idx         <= '0;
          end else begin
            r_cnt <= r_cnt + SCORE_W'(w_covered);
            r_idx <= r_idx + ADDR_W'(1);
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign X           = r_x;
  assign Y           = r_y;
  assign busy        = r_busy;
  assign score_valid = r_score_valid;
  assign score       = r_score;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_laser_stim_scorer.sv
// Directed bench: stimulus pushes expected score/timeout events, a monitor pops and compares.
module tb_laser_stim_scorer;

  localparam int NP = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [3:0] wr_x = '0, wr_y = '0;
  logic       start = 1'b0;
  logic [3:0] X, Y;
  logic       DONE = 1'b0;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic       busy, score_valid, timeout;
  logic [5:0] score;

  laser_stim_scorer #(
    .N_POINTS    (40),
    .R_SQ        (16),
    .TIMEOUT_CYC (4096)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .start       (start),
    .X           (X),
    .Y           (Y),
    .DONE        (DONE),
    .C1X         (C1X),
    .C1Y         (C1Y),
    .C2X         (C2X),
    .C2Y         (C2Y),
    .busy        (busy),
    .score_valid (score_valid),
    .score       (score),
    .timeout     (timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_to;
    logic [5:0] score;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] ex [NP];
  logic [3:0] ey [NP];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every score_valid or timeout pulse must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (score_valid || timeout) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse valid=%0b timeout=%0b required none (cyc %0d)",
                 score_valid, timeout, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_timeout", 32'(timeout), 32'(e.is_to));
        chk("pulse_kind_valid", 32'(score_valid), 32'(!e.is_to));
        chk("pulse_cycle", cyc, e.cyc);
        chk("score", 32'(score), 32'(e.score));
      end
    end
  end

  task automatic load_exp();
    for (int k = 0; k < NP; k++) begin
      wr_en = 1'b1; wr_addr = 6'(k); wr_x = ex[k]; wr_y = ey[k];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic fill(input logic [3:0] x, input logic [3:0] y);
    for (int k = 0; k < NP; k++) begin
      ex[k] = x; ey[k] = y;
    end
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  // Checks the burst; optionally pulses DONE or a write at point index k.
  task automatic stream_check(input int s, input int done_k, input int wr_k, input int upto);
    for (int k = 0; k < upto; k++) begin
      chk("stream_cycle", cyc, s + 1 + k);
      chk("stream_x", 32'(X), 32'(ex[k]));
      chk("stream_y", 32'(Y), 32'(ey[k]));
      chk("stream_busy", 32'(busy), 1);
      DONE  = (k == done_k);
      wr_en = (k == wr_k);
      wr_addr = '0; wr_x = 4'd1; wr_y = 4'd1;
      if (k < upto - 1 || upto == NP) tick();
    end
    DONE = 1'b0;
    wr_en = 1'b0;
    if (upto == NP) begin
      chk("post_stream_x", 32'(X), 0);
      chk("post_stream_y", 32'(Y), 0);
      chk("wait_busy", 32'(busy), 1);
    end
  endtask

  task automatic send_done(input int n, input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y, input int exp_score);
    exp_t e;
    repeat (n) tick();
    C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
    DONE = 1'b1;
    e.is_to = 1'b0; e.score = 6'(exp_score); e.cyc = cyc + NP + 1;
    q.push_back(e);
    tick();
    DONE = 1'b0;
    C1X = 4'hF; C1Y = 4'h0; C2X = 4'h0; C2Y = 4'hF;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
      q.delete();
    end
    tick();
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int s;
    exp_t e;

    // Reset values
    repeat (3) tick();
    chk("rst_x", 32'(X), 0);
    chk("rst_y", 32'(Y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(score_valid), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_timeout", 32'(timeout), 0);
    RST = 1'b0;
    tick();

    // Load pattern (k%16, k/4); DONE during stream is ignored; 10 covered points
    for (int k = 0; k < NP; k++) begin
      ex[k] = 4'(k % 16); ey[k] = 4'(k / 4);
    end
    load_exp();
    do_start(s);
    stream_check(s, 5, -1, NP);
    send_done(10, 4'd0, 4'd0, 4'd15, 4'd7, 10);
    drain(100);

    // Full coverage; write to entry 0 in the start cycle lands in the stream
    fill(4'd5, 4'd5);
    load_exp();
    wr_en = 1'b1; wr_addr = '0; wr_x = 4'd9; wr_y = 4'd9;
    tick();
    wr_x = 4'd5; wr_y = 4'd5;
    do_start(s);
    wr_en = 1'b0;
    stream_check(s, -1, -1, NP);
    send_done(10, 4'd5, 4'd5, 4'd12, 4'd12, 40);
    drain(100);

    // Radius edge: d2=16 counts, d2=17 does not
    fill(4'd15, 4'd15);
    ex[0] = 4'd0; ey[0] = 4'd0;
    load_exp();
    do_start(s);
    stream_check(s, -1, -1, NP);
    send_done(2, 4'd4, 4'd0, 4'd4, 4'd1, 1);
    drain(100);
    do_start(s);
    stream_check(s, -1, -1, NP);
    send_done(0, 4'd4, 4'd1, 4'd4, 4'd1, 0);
    drain(100);

    // Overlap counts once; out-of-range writes are dropped
    fill(4'd8, 4'd8);
    load_exp();
    wr_en = 1'b1; wr_x = 4'd7; wr_y = 4'd7;
    wr_addr = 6'd40; tick();
    wr_addr = 6'd63; tick();
    wr_en = 1'b0;
    do_start(s);
    stream_check(s, -1, -1, NP);
    send_done(4, 4'd8, 4'd8, 4'd9, 4'd8, 40);
    drain(100);

    // Timeout with a write during stream and a start while waiting
    do_start(s);
    stream_check(s, -1, 7, NP);
    e.is_to = 1'b1; e.score = 6'd40; e.cyc = s + NP + 4097;
    q.push_back(e);
    repeat (100) tick();
    start = 1'b1; tick(); start = 1'b0;
    drain(5000);
    chk("to_idle_x", 32'(X), 0);

    // Reset at stream point 20 aborts silently
    do_start(s);
    stream_check(s, -1, -1, 21);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_x", 32'(X), 0);
    chk("mid_rst_y", 32'(Y), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_score", 32'(score), 0);
    repeat (60) tick();
    chk("mid_rst_no_pulse_pending", q.size(), 0);

    // Buffer survived reset and ignored busy write
    do_start(s);
    stream_check(s, -1, -1, NP);
    send_done(3, 4'd8, 4'd8, 4'd0, 4'd0, 40);
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/laser_stim_scorer.md
LASER_STIM_SCORER -- requirements
Module: laser_stim_scorer

Interface
REQ-001 SHALL have parameter N_POINTS, default 40, meaning points per burst.
REQ-002 SHALL have parameter R_SQ, default 16, meaning the squared coverage radius.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, meaning the maximum number of cycles waiting for DONE.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1 bit: point-buffer write strobe.
REQ-007 SHALL have port wr_addr, input, 6 bits: point index.
REQ-008 SHALL have ports wr_x and wr_y, input, 4 bits each: point coordinates.
REQ-009 SHALL have port start, input, 1 bit: request one burst-and-score run.
REQ-010 SHALL have ports X and Y, output, 4 bits each: point stream to the LASER block.
REQ-011 SHALL have port DONE, input, 1 bit: result-ready indication from the LASER block.
REQ-012 SHALL have ports C1X, C1Y, C2X and C2Y, input, 4 bits each: circle centres from the LASER block.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port score_valid, output, 1 bit: one-cycle pulse marking a valid score.
REQ-015 SHALL have port score, output, 6 bits: number of covered points, held until the next run.
REQ-016 SHALL have port timeout, output, 1 bit: one-cycle pulse on watchdog expiry.

Function
REQ-017 SHALL implement the FSM IDLE -> STREAM -> WAIT_DONE -> SCORE -> REPORT -> IDLE, with the single exception that WAIT_DONE goes to IDLE on timeout.
REQ-018 SHALL, in IDLE with start=1, enter STREAM; start is ignored in every other state.
REQ-019 SHALL drive point k onto X/Y in the (k+1)-th cycle after start is accepted, for k = 0..N_POINTS-1, one point per cycle with no gaps.
REQ-020 SHALL drive X and Y to 0 in every cycle outside STREAM.
REQ-021 SHALL leave STREAM after point N_POINTS-1 and enter WAIT_DONE; a DONE=1 seen during STREAM is ignored.
REQ-022 SHALL, in WAIT_DONE on DONE=1, register C1X, C1Y, C2X and C2Y in that cycle and enter SCORE with the point index at 0.
REQ-023 SHALL, in SCORE, evaluate one point per cycle for N_POINTS cycles, then enter REPORT.
REQ-024 SHALL compute each distance as dx = x - cx and dy = y - cy (5-bit signed), d2 = dx*dx + dy*dy (9-bit unsigned), with "covered" meaning d2 <= R_SQ.
REQ-025 SHALL count a point once when it is covered by C1 or C2 or both.
REQ-026 SHALL pulse score_valid for exactly one cycle, in REPORT, with score updated in that same cycle; for DONE sampled in cycle d, score_valid is high in cycle d+N_POINTS+1.
REQ-027 SHALL count WAIT_DONE cycles and, when the count reaches TIMEOUT_CYC, pulse timeout for one cycle, return to IDLE, and leave score unchanged with no score_valid.
REQ-028 SHALL write the buffer entry at wr_addr when wr_en=1 in IDLE; writes in any other state are ignored.
REQ-029 SHALL ignore writes with wr_addr >= N_POINTS.
REQ-030 SHALL, when wr_en and start arrive in the same IDLE cycle, apply the write and accept start, so the stream uses the new value.
REQ-031 SHALL keep the score counter wide enough for N_POINTS with no wrap-around (40 fits in 6 bits).

Reset
REQ-032 SHALL, on RST=1 at a clock edge, set state=IDLE, X=Y=0, busy=0, score_valid=0, score=0, timeout=0, and clear the captured centres and all counters.
REQ-033 SHALL, on reset mid-run, abort the run with no score_valid or timeout pulse.
REQ-034 SHALL leave point-buffer contents unaffected by reset.

Structure
REQ-035 SHALL place the FSM state encodings, N_POINTS, R_SQ and TIMEOUT_CYC defaults in the shared laser_pkg package.
REQ-036 SHALL implement the covered-test arithmetic (two d2 computations and compares) as the combinational sub-module laser_cover_chk, instantiated once.

Verification
REQ-037 SHALL cover load: points k=(k%16, k/4), start -> X/Y carries exactly those 40 values in 40 consecutive cycles, and busy=1 throughout.
REQ-038 SHALL cover full coverage: all points at (5,5), centres (5,5) and (12,12), DONE after 10 cycles -> score=40, score_valid exactly 41 cycles after DONE.
REQ-039 SHALL cover the radius edge: point (0,0), centre (4,0) counts (d2=16), centre (4,1) does not (d2=17), remaining points far away -> score=1.
REQ-040 SHALL cover overlap: 40 points all inside both circles -> score=40, not 80.
REQ-041 SHALL cover timeout: DONE never asserted -> timeout pulse after 4096 WAIT_DONE cycles, then IDLE with score unchanged.
REQ-042 SHALL cover reset and ignored inputs: RST at stream cycle 20 -> X=Y=0 the next cycle and busy=0; start while busy is ignored; wr_en while busy leaves the buffer unchanged.
